// File: rtl/run_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_seq_pkg -- sequencer state encoding and index-width helper.  Rev 1.0
// ---------------------------------------------------------------------------
package run_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_RECORD = 3'd4,
    ST_DONE   = 3'd5
  } run_state_t;

  // A single-program batch still needs a 1-bit program index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_sequencer_cycle_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cycle_timer -- clearable, enable-gated saturating counter with limit flag.  Rev 1.0
// ---------------------------------------------------------------------------
module cycle_timer #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_limit_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Saturate at all-ones so settle delays longer than the run limit still count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (en_i && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  assign count_o    = cnt_q;
  assign at_limit_o = (cnt_q >= LIMIT);

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_sequencer -- batch controller for the core start/halt handshake.  Rev 1.0
// ---------------------------------------------------------------------------
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS   = 4,
  parameter int START_DELAY = 10,
  parameter int START_WIDTH = 1,
  parameter int MAX_CYCLES  = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic                               go,
  input  logic                               halt,
  output logic                               start,
  output logic [idx_width(NUM_PROGS)-1:0]    prog_sel,
  output logic                               busy,
  output logic                               run_valid,
  output logic [CNT_W-1:0]                   run_cycles,
  output logic                               run_timeout,
  output logic                               batch_done,
  output logic [$clog2(NUM_PROGS+1)-1:0]     fail_count
);

  localparam int PW = idx_width(NUM_PROGS);
  localparam int FW = $clog2(NUM_PROGS + 1);
  localparam logic [PW-1:0]    PROG_LAST   = PW'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(MAX_CYCLES);

  run_state_t       state_q, state_d;
  logic [PW-1:0]    prog_q, prog_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             timeout_q, timeout_d;

  logic             tmr_clr, tmr_en, tmr_at_limit;
  logic [CNT_W-1:0] tmr_count;

  // One timer serves SETTLE, START and RUN; every phase change restarts it at 0.
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (state_q == ST_SETTLE) || (state_q == ST_START) ||
                   ((state_q == ST_RUN) && !halt);

  cycle_timer #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .clr_i      (tmr_clr),
    .en_i       (tmr_en),
    .count_o    (tmr_count),
    .at_limit_o (tmr_at_limit)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Halt is checked before the limit so a halt on the limit cycle is not a timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (go) state_d = ST_SETTLE;
      ST_SETTLE: if (tmr_count == SETTLE_LAST) state_d = ST_START;
      ST_START:  if (tmr_count == START_LAST) state_d = ST_RUN;
      ST_RUN:    if (halt || tmr_at_limit) state_d = ST_RECORD;
      ST_RECORD: state_d = (prog_q == PROG_LAST) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start      = (state_q == ST_START);
    busy       = (state_q != ST_IDLE);
    run_valid  = (state_q == ST_RECORD);
    batch_done = (state_q == ST_DONE);
  end

  always_comb begin
    prog_d    = prog_q;
    fail_d    = fail_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          prog_d = '0;
          fail_d = '0;
        end
      end
      ST_RUN: begin
        if (halt) begin
          cycles_d  = tmr_count;
          timeout_d = 1'b0;
        end else if (tmr_at_limit) begin
          cycles_d  = CNT_LIMIT;
          timeout_d = 1'b1;
        end
      end
      ST_RECORD: begin
        fail_d = fail_q + FW'(timeout_q);
        if (prog_q != PROG_LAST) prog_d = prog_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prog_q    <= '0;
      fail_q    <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      prog_q    <= prog_d;
      fail_q    <= fail_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
    end
  end

  assign prog_sel    = prog_q;
  assign fail_count  = fail_q;
  assign run_cycles  = cycles_q;
  assign run_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_run_sequencer -- self-checking bench for run_sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_run_sequencer;

  localparam int NP = 4;
  localparam int SD = 10;
  localparam int SW = 2;
  localparam int MC = 20;
  localparam int CW = 8;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int FW = $clog2(NP + 1);

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic go = 1'b0;
  logic halt = 1'b0;
  logic start, busy, run_valid, run_timeout, batch_done;
  logic [PW-1:0] prog_sel;
  logic [CW-1:0] run_cycles;
  logic [FW-1:0] fail_count;

  int checks = 0;
  int errors = 0;
  int hs[NP];
  int exp_fail = 0;

  always #5 CLK = ~CLK;

  run_sequencer #(
    .NUM_PROGS   (NP),
    .START_DELAY (SD),
    .START_WIDTH (SW),
    .MAX_CYCLES  (MC),
    .CNT_W       (CW)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .go          (go),
    .halt        (halt),
    .start       (start),
    .prog_sel    (prog_sel),
    .busy        (busy),
    .run_valid   (run_valid),
    .run_cycles  (run_cycles),
    .run_timeout (run_timeout),
    .batch_done  (batch_done),
    .fail_count  (fail_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered in the first settle cycle of run k; halt rises h cycles into the run.
  task automatic run_one(input int k, input int h, input bit stale, input bit go_noise);
    int n;
    int j;
    int exp_c;
    bit exp_to;
    halt = stale;
    go   = go_noise;
    check("settle_prog_sel", prog_sel, k);
    n = 0;
    while (!start && n < SD + 5) begin
      tick();
      n++;
    end
    go = 1'b0;
    check("start_latency", n, SD);
    check("start_prog_sel", prog_sel, k);
    n = 0;
    while (start && n < SW + 5) begin
      tick();
      n++;
    end
    check("start_width", n, SW);
    j = 0;
    halt = (h == 0);
    while (!run_valid && j < MC + 5) begin
      tick();
      if (!run_valid) begin
        j++;
        halt = (j >= h);
      end
    end
    exp_c  = (h <= MC) ? h : MC;
    exp_to = (h > MC);
    if (exp_to) exp_fail++;
    check("record_cycle", j, exp_c);
    check("run_valid", run_valid, 1);
    check("run_cycles", run_cycles, exp_c);
    check("run_timeout", run_timeout, exp_to);
    if (!stale) halt = 1'b0;
    tick();
    check("run_valid_strobe", run_valid, 0);
    check("run_cycles_hold", run_cycles, exp_c);
    check("fail_count", fail_count, exp_fail);
  endtask

  task automatic run_batch(input bit stale, input bit go_noise);
    exp_fail = 0;
    check("idle_busy", busy, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("busy_accept", busy, 1);
    for (int k = 0; k < NP; k++) run_one(k, hs[k], stale, go_noise);
    check("batch_done", batch_done, 1);
    check("busy_done", busy, 1);
    tick();
    check("batch_done_strobe", batch_done, 0);
    check("busy_idle", busy, 0);
    check("fail_count_held", fail_count, exp_fail);
    halt = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_run_valid", run_valid, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_prog_sel", prog_sel, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_run_timeout", run_timeout, 0);
    check("rst_fail_count", fail_count, 0);
    RESET_N = 1'b1;
    tick();
    tick();

    // Plain batch with distinct halt delays
    hs = '{5, 7, 9, 11};
    run_batch(1'b0, 1'b0);

    // Timeouts, exact-limit halt, immediate halt; go held during settle is ignored
    hs = '{MC + 1, MC + 3, MC, 0};
    run_batch(1'b0, 1'b1);

    // Halt left high from the previous run must not end the next run early
    hs = '{0, 0, 3, 0};
    run_batch(1'b1, 1'b0);

    // Reset in the middle of run 1
    exp_fail = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    run_one(0, MC + 2, 1'b0, 1'b0);
    n = 0;
    while (!start && n < SD + 5) begin
      tick();
      n++;
    end
    n = 0;
    while (start && n < SW + 5) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("pre_reset_busy", busy, 1);
    RESET_N = 1'b0;
    #1;
    check("arst_start", start, 0);
    check("arst_busy", busy, 0);
    check("arst_prog_sel", prog_sel, 0);
    check("arst_fail_count", fail_count, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_run_valid", run_valid, 0);
      check("arst_batch_done", batch_done, 0);
    end
    RESET_N = 1'b1;
    tick();
    check("post_reset_busy", busy, 0);

    // Randomized batches
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < NP; k++) hs[k] = int'($urandom_range(0, MC + 3));
      run_batch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Synthesizable run controller that drives the processor core's start/halt handshake, replacing fixed-delay bench sequencing. Executes a batch of NUM_PROGS program runs back-to-back: selects a program, waits a settle delay, pulses start, then counts cycles until halt or timeout. Reports per-run cycle count and status. Sits between a host/bench and TopLevel.

Parameters:
NUM_PROGS, 4, number of programs in a batch (>=1)
START_DELAY, 10, cycles between run setup and start pulse (>=1)
START_WIDTH, 1, start pulse length in cycles (>=1)
MAX_CYCLES, 1024, timeout limit per run (>=2)
CNT_W, 16, cycle counter width; must satisfy 2**CNT_W > MAX_CYCLES

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
go  input  1  begin batch; sampled only in IDLE
halt  input  1  core halt, level
start  output  1  pulse to core
prog_sel  output  $clog2(NUM_PROGS) (min 1)  program index of current run
busy  output  1  high from go accept until DONE exit
run_valid  output  1  one-cycle strobe, run result valid
run_cycles  output  CNT_W  cycles from start deassertion to halt (or MAX_CYCLES)
run_timeout  output  1  qualifies run_valid: run hit MAX_CYCLES
batch_done  output  1  one-cycle strobe after last run recorded
fail_count  output  $clog2(NUM_PROGS+1)  timeouts in current/last batch

Behaviour:
- One clock (CLK); reset asynchronous, active-low (RESET_N). During/after reset: state IDLE, all outputs 0, counters 0.
- States: IDLE, SETTLE, START, RUN, RECORD, DONE.
- IDLE: go=1 -> SETTLE next cycle; prog_sel<=0, fail_count<=0, busy<=1. go ignored in all other states.
- SETTLE: counts START_DELAY cycles, then START. prog_sel stable throughout.
- START: start=1 for exactly START_WIDTH cycles, then RUN; cycle counter cleared on entry to RUN.
- RUN: counter increments each cycle halt=0. halt sampled high in RUN -> RECORD with run_cycles = counter value (first RUN cycle with halt=1 gives 0). Counter reaching MAX_CYCLES with halt low -> RECORD, run_timeout=1, run_cycles=MAX_CYCLES. Halt and limit in same cycle: halt wins (no timeout).
- halt high during SETTLE/START ignored (stale halt from prior run); only RUN samples it.
- RECORD (1 cycle): run_valid=1; run_cycles/run_timeout held until next RECORD. fail_count += timeout. If prog_sel==NUM_PROGS-1 -> DONE, else prog_sel+1 -> SETTLE.
- DONE (1 cycle): batch_done=1, busy<=0 on exit, -> IDLE. fail_count held until next go.
- Counter saturates; never wraps. prog_sel never exceeds NUM_PROGS-1.
- RESET_N low mid-run: immediate return to IDLE, start deasserted asynchronously, no run_valid/batch_done.
- Latency go->first start: 1 + START_DELAY cycles.

Decomposition:
- Package run_seq_pkg: state enum typedef (run_state_t), helper for index width (max(1,$clog2(N))).
- Sub-module cycle_timer: clearable, enable-gated saturating counter with limit flag (CNT_W, MAX_CYCLES); instantiated once, shared by SETTLE and RUN phases.

Test Plan:
- NUM_PROGS=1, START_DELAY=10: go at cycle 0, halt after 50 RUN cycles -> start high cycle 11, run_valid with run_cycles=50, run_timeout=0, batch_done next cycle, busy low after.
- NUM_PROGS=4, halts after 5/7/9/11 cycles -> four run_valid strobes, prog_sel 0..3, run_cycles 5,7,9,11, fail_count=0.
- MAX_CYCLES=20, halt never asserted -> run_cycles=20, run_timeout=1, fail_count=1; halt at exactly cycle 20 -> run_timeout=0.
- halt held high through SETTLE/START from previous run -> not counted; RUN entry with halt=1 gives run_cycles=0.
- RESET_N pulsed low during RUN -> start=0, busy=0 immediately, no run_valid; go afterward restarts at prog_sel=0.
- go asserted while busy -> ignored; batch completes normally, fail_count unchanged.
